serial_frame_ctrl: RTL and testbench

//  Sequences the UART receive engine: drives its bit-period limit from a baud select, edge-detects its byte strobe,
//  and parses frames: SOF 0xA5, LEN, LEN payload bytes, CHK.

---
 rtl/serial_frame_ctrl_pkg.sv | 41 ++++
 rtl/serial_frame_ctrl_frame_buf.sv | 29 ++
 rtl/serial_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_serial_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_ctrl_pkg.sv
// ============================================================================
// serial_pkg : shared constants, state encoding and baud table for the frame ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_pkg;

  localparam logic [7:0]  SOF_BYTE     = 8'hA5;

  localparam logic [15:0] LIMIT_9600   = 16'd5208;
  localparam logic [15:0] LIMIT_19200  = 16'd2604;
  localparam logic [15:0] LIMIT_57600  = 16'd868;
  localparam logic [15:0] LIMIT_115200 = 16'd434;

  localparam logic [2:0]  ST_IDLE      = 3'd0;
  localparam logic [2:0]  ST_LEN       = 3'd1;
  localparam logic [2:0]  ST_PAYLOAD   = 3'd2;
  localparam logic [2:0]  ST_CHK       = 3'd3;
  localparam logic [2:0]  ST_DRAIN     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LEN     = ST_LEN,
    S_PAYLOAD = ST_PAYLOAD,
    S_CHK     = ST_CHK,
    S_DRAIN   = ST_DRAIN
  } state_t;

  function automatic logic [15:0] baud_limit(input logic [1:0] sel);
    case (sel)
      2'd0:    baud_limit = LIMIT_9600;
      2'd1:    baud_limit = LIMIT_19200;
      2'd2:    baud_limit = LIMIT_57600;
      default: baud_limit = LIMIT_115200;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_frame_ctrl_frame_buf.sv
// ============================================================================
// frame_buf : DEPTH x 8 register array, synchronous write, asynchronous read
// Revision: 1.0
// ============================================================================
`default_nettype none

module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/serial_frame_ctrl.sv
// ============================================================================
// serial_frame_ctrl : UART byte-strobe framing (SOF/LEN/payload/CHK), buffered
//                     ready/valid payload release, error pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  baud_sel,
  output logic [15:0] limit,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        err_chk,
  output logic        err_len,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = AW + 1;

  state_t          r_state, w_state_nxt;
  logic            r_rx_valid_q;
  logic            w_stb;
  logic [CW-1:0]   r_len, w_len_nxt;
  logic [CW-1:0]   r_idx, w_idx_nxt;
  logic [CW-1:0]   r_rd, w_rd_nxt;
  logic [7:0]      r_sum, w_sum_nxt;
  logic [15:0]     r_tmo_cnt;
  logic            w_tmo_active, w_tmo_hit;
  logic            w_wr_en;
  logic [7:0]      w_rd_data;
  logic            w_err_chk, w_err_len, w_err_tmo, w_err_ovr;
  logic            r_err_chk, r_err_len, r_err_tmo, r_err_ovr;

  assign w_stb        = rx_valid & ~r_rx_valid_q;
  assign w_tmo_active = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
  // A strobe in the same cycle always beats the timeout.
  assign w_tmo_hit    = w_tmo_active && !w_stb && ((int'(r_tmo_cnt) + 1) >= TIMEOUT);

  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_frame_buf (
    .Clk     (Clk),
    .wr_en   (w_wr_en),
    .wr_addr (r_idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (r_rd[AW-1:0]),
    .rd_data (w_rd_data)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state      <= S_IDLE;
      r_rx_valid_q <= 1'b1;
      r_len        <= '0;
      r_idx        <= '0;
      r_rd         <= '0;
      r_sum        <= '0;
      r_tmo_cnt    <= '0;
      limit        <= LIMIT_115200;
      r_err_chk    <= 1'b0;
      r_err_len    <= 1'b0;
      r_err_tmo    <= 1'b0;
      r_err_ovr    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rx_valid_q <= rx_valid;
      r_len        <= w_len_nxt;
      r_idx        <= w_idx_nxt;
      r_rd         <= w_rd_nxt;
      r_sum        <= w_sum_nxt;
      r_err_chk    <= w_err_chk;
      r_err_len    <= w_err_len;
      r_err_tmo    <= w_err_tmo;
      r_err_ovr    <= w_err_ovr;
      if (r_state == S_IDLE) limit <= baud_limit(baud_sel);
      if (!w_tmo_active || w_stb)  r_tmo_cnt <= '0;
      else if (r_tmo_cnt != 16'hFFFF) r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_rd_nxt    = r_rd;
    w_sum_nxt   = r_sum;
    w_wr_en     = 1'b0;
    w_err_chk   = 1'b0;
    w_err_len   = 1'b0;
    w_err_tmo   = 1'b0;
    w_err_ovr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_stb && rx_data == SOF_BYTE) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (w_stb) begin
          if (rx_data != 8'd0 && int'(rx_data) <= MAX_LEN) begin
            w_len_nxt   = rx_data[CW-1:0];
            w_sum_nxt   = rx_data;
            w_idx_nxt   = '0;
            w_state_nxt = S_PAYLOAD;
          end else begin
            w_err_len   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PAYLOAD: begin
        if (w_stb) begin
          w_wr_en   = 1'b1;
          w_sum_nxt = r_sum + rx_data;
          w_idx_nxt = r_idx + CW'(1);
          if (r_idx == r_len - CW'(1)) w_state_nxt = S_CHK;
        end else if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CHK: begin
        if (w_stb) begin
          if (8'(r_sum + rx_data) == 8'd0) begin
            w_rd_nxt    = '0;
            w_state_nxt = S_DRAIN;
          end else begin
            w_err_chk   = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err_tmo   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Bytes arriving while draining are dropped, not parsed.
        if (w_stb) w_err_ovr = 1'b1;
        if (out_ready) begin
          w_rd_nxt = r_rd + CW'(1);
          if (r_rd == r_len - CW'(1)) w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign out_valid   = (r_state == S_DRAIN);
  assign out_last    = out_valid && (r_rd == r_len - CW'(1));
  assign out_data    = out_valid ? w_rd_data : 8'h00;
  assign busy        = (r_state != S_IDLE);
  assign err_chk     = r_err_chk;
  assign err_len     = r_err_len;
  assign err_timeout = r_err_tmo;
  assign err_overrun = r_err_ovr;

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_ctrl.sv
// ============================================================================
// tb_serial_frame_ctrl : scoreboard bench, frame-level reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_ctrl;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 300;
  localparam int E_CHK = 0, E_LEN = 1, E_TMO = 2, E_OVR = 3;

  logic        Clk = 1'b0;
  logic        Rst;
  logic [1:0]  baud_sel;
  logic [15:0] limit;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        err_chk, err_len, err_timeout, err_overrun;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode;
  logic [8:0]  exp_out_q[$];
  int          exp_err_q[$];
  logic [7:0]  pl_q[$];
  logic [7:0]  chk_b;

  always #5 Clk = ~Clk;

  serial_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .Clk(Clk), .Rst(Rst), .baud_sel(baud_sel), .limit(limit),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .err_chk(err_chk), .err_len(err_len),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // out_ready driver: 0 = low, 1 = high, 2 = random
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge Clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom % 2);
      endcase
    end
  end

  // Monitor: pops scoreboard entries whenever the DUT presents a byte or an error.
  initial begin
    logic [3:0] got;
    forever begin
      @(negedge Clk);
      if (!Rst) begin
        if (out_valid && out_ready) begin
          if (exp_out_q.size() == 0) flag("unexpected_out_byte");
          else check("out_byte", {23'd0, out_last, out_data}, {23'd0, exp_out_q.pop_front()});
        end
        got = {err_overrun, err_timeout, err_len, err_chk};
        if (got != 4'd0) begin
          if (exp_err_q.size() == 0) flag("unexpected_err_pulse");
          else check("err_kind", {28'd0, got}, 32'd1 << exp_err_q.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1 rx_valid = 1'b0;
    @(posedge Clk); #1 rx_data = b; rx_valid = 1'b1;
    repeat ($urandom_range(1, 4)) @(posedge Clk);
  endtask

  // Reference model for a well-formed frame: random payload, checksum makes the frame sum to zero.
  task automatic model_good(input int len, input bit corrupt);
    logic [7:0] sum;
    pl_q.delete();
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      pl_q.push_back(8'($urandom));
      sum = sum + pl_q[i];
    end
    chk_b = 8'(0) - sum;
    if (corrupt) begin
      chk_b = chk_b ^ 8'($urandom_range(1, 255));
      exp_err_q.push_back(E_CHK);
    end else begin
      for (int i = 0; i < len; i++) exp_out_q.push_back({(i == len - 1), pl_q[i]});
    end
  endtask

  task automatic send_body(input int len);
    send_byte(8'hA5);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) send_byte(pl_q[i]);
    send_byte(chk_b);
  endtask

  task automatic run_frame(input int len, input bit corrupt);
    if (len == 0 || len > MAX_LEN) begin
      exp_err_q.push_back(E_LEN);
      send_byte(8'hA5);
      send_byte(8'(len));
    end else begin
      model_good(len, corrupt);
      send_body(len);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy || exp_out_q.size() != 0) && k < 3000) begin
      @(posedge Clk);
      k++;
    end
    if (k >= 3000) flag("wait_idle_timeout");
    repeat (3) @(posedge Clk);
    check("err_queue_drained", exp_err_q.size(), 0);
    check("out_queue_drained", exp_out_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; baud_sel = 2'd3; ready_mode = 1;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_limit", limit, 16'd434);
    check("rst_outs", {out_valid, out_last, busy, out_data}, 0);
    check("rst_errs", {err_chk, err_len, err_timeout, err_overrun}, 0);
    Rst = 1'b0;

    // 1: basic good frame
    exp_out_q.push_back({1'b0, 8'h11});
    exp_out_q.push_back({1'b0, 8'h22});
    exp_out_q.push_back({1'b1, 8'h33});
    foreach (pl_q[i]) pl_q[i] = 8'h00;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
    wait_idle();
    check("busy_after_drain", busy, 0);

    // 2: bad checksum, then a good frame
    exp_err_q.push_back(E_CHK);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
    wait_idle();
    exp_out_q.push_back({1'b1, 8'h7F});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    wait_idle();

    // 3: length boundaries
    exp_err_q.push_back(E_LEN);
    send_byte(8'hA5); send_byte(8'h00);
    check("idle_after_len0", busy, 0);
    exp_err_q.push_back(E_LEN);
    send_byte(8'hA5); send_byte(8'h11);
    check("idle_after_len17", busy, 0);
    wait_idle();
    run_frame(MAX_LEN, 1'b0);
    wait_idle();

    // 4: inter-byte timeout, then recovery
    exp_err_q.push_back(E_TMO);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    repeat (TIMEOUT + 20) @(posedge Clk);
    #1 check("idle_after_timeout", busy, 0);
    wait_idle();
    exp_out_q.push_back({1'b1, 8'h05});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'hFA);
    wait_idle();

    // 5: back-pressure with overrun during drain
    ready_mode = 0;
    model_good(4, 1'b0);
    send_body(4);
    begin
      int k = 0;
      while (!out_valid && k < 100) begin @(posedge Clk); k++; end
      if (k >= 100) flag("drain_never_started");
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      check("hold_data", {23'd0, out_valid, out_data}, {23'd0, 1'b1, pl_q[0]});
    end
    exp_err_q.push_back(E_OVR);
    send_byte(8'h55);
    @(negedge Clk);
    check("hold_after_overrun", {23'd0, out_valid, out_data}, {23'd0, 1'b1, pl_q[0]});
    ready_mode = 1;
    wait_idle();

    // 6: baud select only takes effect in IDLE
    model_good(2, 1'b0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(pl_q[0]);
    baud_sel = 2'd0;
    repeat (4) @(posedge Clk);
    #1 check("limit_frozen_midframe", limit, 16'd434);
    send_byte(pl_q[1]); send_byte(chk_b);
    wait_idle();
    #1 check("limit_9600", limit, 16'd5208);
    baud_sel = 2'd1; repeat (2) @(posedge Clk);
    #1 check("limit_19200", limit, 16'd2604);
    baud_sel = 2'd2; repeat (2) @(posedge Clk);
    #1 check("limit_57600", limit, 16'd868);
    baud_sel = 2'd0;

    // reset in the middle of a payload
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    @(posedge Clk); #1 Rst = 1'b1;
    @(posedge Clk); #1;
    check("midrst_limit", limit, 16'd434);
    check("midrst_outs", {out_valid, out_last, busy, out_data}, 0);
    check("midrst_errs", {err_chk, err_len, err_timeout, err_overrun}, 0);
    Rst = 1'b0;
    baud_sel = 2'd3;
    exp_out_q.push_back({1'b1, 8'h7F});
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    wait_idle();

    // randomized frames with garbage between them and random back-pressure
    ready_mode = 2;
    for (int f = 0; f < 25; f++) begin
      int ng;
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        logic [7:0] gb;
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h5A;
        send_byte(gb);
      end
      run_frame($urandom_range(0, MAX_LEN + 2), ($urandom % 4) == 0);
      wait_idle();
    end
    ready_mode = 1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
